// File: rtl/div_pkg.sv
// div_pkg: state encoding, default sizes and the divide-by-zero quotient helper
package div_pkg;
   localparam int DEF_WIDTH = 4;
   localparam int DEF_NREQ = 4;
   localparam int QMAX = 64;
   typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
   function automatic logic [QMAX-1:0] dbz_quo(input int w);
      dbz_quo = '0;
      for (int i = 0; i < QMAX; i++) if (i < w) dbz_quo[i] = 1'b1;
   endfunction
endpackage

// File: rtl/div_core.sv
// div_core: restoring divider, one quotient bit per cycle MSB first, 2*WIDTH iterations
module div_core import div_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   localparam int W2 = 2 * WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W2-1:0]    dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [W2-1:0]    quo,
   output logic [W2-1:0]    rem
);
   localparam int CW = $clog2(W2 + 1);
   logic [W2-1:0] dq, pr;
   logic [WIDTH-1:0] dvs;
   logic [CW-1:0] cnt;
   logic [W2:0] shifted, diff;
   logic qbit;
   // dq shifts dividend bits out at the top while quotient bits enter at the bottom
   assign shifted = {pr, dq[W2-1]};
   assign diff = shifted - (W2+1)'(dvs);
   assign qbit = shifted >= (W2+1)'(dvs);
   assign quo = {dq[W2-2:0], qbit};
   assign rem = W2'(qbit ? diff : shifted);
   assign done = cnt == CW'(1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         dq <= '0;
         pr <= '0;
         dvs <= '0;
         cnt <= '0;
      end else if (start) begin
         dq <= dividend;
         pr <= '0;
         dvs <= divisor;
         cnt <= CW'(W2);
      end else if (cnt != '0) begin
         dq <= quo;
         pr <= rem;
         cnt <= cnt - CW'(1);
      end
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one iterative divider among NREQ requesters.
// Define DIV_ARB_FAST_PATH_EN to answer dividend < divisor without running the core.
module div_arbiter import div_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ = DEF_NREQ,
   localparam int IDW = $clog2(NREQ),
   localparam int W2 = 2 * WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*W2-1:0]    req_dividend,
   input  logic [NREQ*WIDTH-1:0] req_divisor,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [W2-1:0]         rsp_quo,
   output logic [W2-1:0]         rsp_rem,
   output logic                  rsp_dbz,
   output logic                  busy
);
   state_t state, nxt;
   logic [IDW-1:0] rr_ptr, gid, idx;
   logic found, grant, start, fast, done, zero;
   logic [W2-1:0] dvd_g, core_quo, core_rem;
   logic [WIDTH-1:0] dvs_g;
   // first valid requester after the last winner, wrapping around
   always_comb begin
      found = 1'b0;
      gid = '0;
      idx = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = IDW'((int'(rr_ptr) + i) % NREQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gid = idx;
         end
      end
   end
   assign grant = state == IDLE && found;
   assign req_ready = grant ? NREQ'(1) << gid : '0;
   assign dvd_g = req_dividend[gid*W2 +: W2];
   assign dvs_g = req_divisor[gid*WIDTH +: WIDTH];
   assign zero = dvs_g == '0;
`ifdef DIV_ARB_FAST_PATH_EN
   assign fast = dvd_g < W2'(dvs_g);
`else
   assign fast = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state == IDLE ? (grant ? (zero || fast ? RESP : RUN) : IDLE)
          : state == RUN  ? (done ? RESP : RUN)
          : (rsp_ready ? IDLE : RESP);
      start = grant && !zero && !fast;
   end
   // zero-divisor and fast-path results are final at grant; the core overwrites the rest
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rr_ptr <= IDW'(NREQ - 1);
         rsp_id <= '0;
         rsp_quo <= '0;
         rsp_rem <= '0;
         rsp_dbz <= 1'b0;
      end else if (grant) begin
         rr_ptr <= gid;
         rsp_id <= gid;
         rsp_dbz <= zero;
         rsp_quo <= zero ? W2'(dbz_quo(W2)) : '0;
         rsp_rem <= dvd_g;
      end else if (state == RUN && done) begin
         rsp_quo <= core_quo;
         rsp_rem <= core_rem;
      end
   assign rsp_valid = state == RESP;
   assign busy = state != IDLE;
   div_core #(.WIDTH(WIDTH)) u_core (
      .clk(clk),
      .rst(rst),
      .start(start),
      .dividend(dvd_g),
      .divisor(dvs_g),
      .done(done),
      .quo(core_quo),
      .rem(core_rem)
   );
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: vector table plus scoreboarded sequences for div_arbiter at WIDTH=4, NREQ=4
module tb_div_arbiter;
   localparam int W = 4;
   localparam int N = 4;
   localparam int W2 = 8;
`ifdef DIV_ARB_FAST_PATH_EN
   localparam int FL = 1;
`else
   localparam int FL = 9;
`endif
   logic clk = 0, rst = 1;
   logic [N-1:0] req_valid = '0, req_ready;
   logic [N*W2-1:0] req_dividend = '0;
   logic [N*W-1:0] req_divisor = '0;
   logic rsp_valid, rsp_ready = 1'b1, rsp_dbz, busy;
   logic [1:0] rsp_id;
   logic [W2-1:0] rsp_quo, rsp_rem;
   int pass_cnt = 0, total = 0;
   typedef struct {int id; int quo; int rem; int dbz;} exp_t;
   typedef struct {int id; int dvd; int dvs; int quo; int rem; int dbz; int lat;} vec_t;
   exp_t sb[$];
   exp_t me;
   vec_t tbl[9];

   always #5 clk = ~clk;

   div_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_quo(rsp_quo), .rsp_rem(rsp_rem), .rsp_dbz(rsp_dbz), .busy(busy)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic push(input int id, input int quo, input int rem, input int dbz);
      exp_t e;
      e = '{id, quo, rem, dbz};
      sb.push_back(e);
   endtask

   task automatic push_model(input int id, input int dvd, input int dvs);
      if (dvs == 0) push(id, 255, dvd, 1);
      else push(id, dvd / dvs, dvd % dvs, 0);
   endtask

   task automatic set_req(input int id, input int dvd, input int dvs);
      req_dividend[id*W2 +: W2] = W2'(dvd);
      req_divisor[id*W +: W] = W'(dvs);
      req_valid[id] = 1'b1;
   endtask

   function automatic int oh_idx(input logic [N-1:0] v);
      oh_idx = -1;
      for (int i = 0; i < N; i++) if (v[i]) oh_idx = i;
   endfunction

   task automatic run_op(input int id, input int dvd, input int dvs, input int quo,
                         input int rem, input int dbz, input int lat);
      int n;
      @(posedge clk); #1;
      set_req(id, dvd, dvs);
      push(id, quo, rem, dbz);
      n = 0;
      @(negedge clk);
      while (!req_ready[id] && n < 50) begin @(negedge clk); n++; end
      chk("grant", int'(req_ready[id]), 1);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      n = 1;
      @(negedge clk);
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      chk("latency", n, lat);
   endtask

   task automatic wait_sb(input int limit);
      int n;
      n = 0;
      while (sb.size() != 0 && n < limit) begin @(negedge clk); n++; end
      chk("drain", sb.size(), 0);
   endtask

   always @(negedge clk)
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
         else begin
            me = sb.pop_front();
            chk("rsp_id", int'(rsp_id), me.id);
            chk("rsp_quo", int'(rsp_quo), me.quo);
            chk("rsp_rem", int'(rsp_rem), me.rem);
            chk("rsp_dbz", int'(rsp_dbz), me.dbz);
         end
      end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, g, seen, q, r;
      tbl[0] = '{1, 100, 7, 14, 2, 0, 9};
      tbl[1] = '{2, 45, 0, 255, 45, 1, 1};
      tbl[2] = '{0, 255, 1, 255, 0, 0, 9};
      tbl[3] = '{3, 255, 15, 17, 0, 0, 9};
      tbl[4] = '{1, 3, 9, 0, 3, 0, FL};
      tbl[5] = '{2, 0, 5, 0, 0, 0, FL};
      tbl[6] = '{0, 200, 13, 15, 5, 0, 9};
      tbl[7] = '{3, 15, 15, 1, 0, 0, 9};
      tbl[8] = '{2, 0, 0, 255, 0, 1, 1};
      @(negedge clk);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_rsp_id", int'(rsp_id), 0);
      chk("rst_rsp_quo", int'(rsp_quo), 0);
      chk("rst_rsp_rem", int'(rsp_rem), 0);
      chk("rst_rsp_dbz", int'(rsp_dbz), 0);
      chk("rst_busy", int'(busy), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      foreach (tbl[i])
         run_op(tbl[i].id, tbl[i].dvd, tbl[i].dvs, tbl[i].quo, tbl[i].rem, tbl[i].dbz, tbl[i].lat);
      wait_sb(20);

      // response back-pressure with another request waiting
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      run_op(0, 77, 6, 12, 5, 0, 9);
      q = int'(rsp_quo);
      r = int'(rsp_rem);
      @(posedge clk); #1;
      set_req(1, 130, 11);
      push(1, 11, 9, 0);
      repeat (5) begin
         @(negedge clk);
         chk("hold_quo", int'(rsp_quo), q);
         chk("hold_rem", int'(rsp_rem), r);
         chk("hold_id", int'(rsp_id), 0);
         chk("hold_valid", int'(rsp_valid), 1);
         chk("hold_req_ready", int'(req_ready), 0);
         chk("hold_busy", int'(busy), 1);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("after_hs_valid", int'(rsp_valid), 0);
      chk("after_hs_busy", int'(busy), 0);
      chk("regrant", int'(req_ready), 2);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      wait_sb(30);

      // all requesters contending from reset
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 50 + 37 * i, 3 + i);
      for (int k = 0; k < 5; k++) push_model(k % N, 50 + 37 * (k % N), 3 + k % N);
      g = 0;
      n = 0;
      while (g < 5 && n < 300) begin
         @(negedge clk);
         n++;
         if (|(req_ready & req_valid)) begin
            chk("rr_order", oh_idx(req_ready), g % N);
            g++;
            if (g == 5) begin @(posedge clk); #1; req_valid = '0; end
         end
      end
      chk("rr_grants", g, 5);
      wait_sb(30);

      // reset in the middle of a running division
      @(posedge clk); #1;
      set_req(2, 100, 7);
      push(2, 14, 2, 0);
      n = 0;
      @(negedge clk);
      while (!req_ready[2] && n < 50) begin @(negedge clk); n++; end
      chk("mid_grant", int'(req_ready[2]), 1);
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("pre_rst_busy", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_valid", int'(rsp_valid), 0);
      chk("arst_id", int'(rsp_id), 0);
      chk("arst_quo", int'(rsp_quo), 0);
      chk("arst_rem", int'(rsp_rem), 0);
      chk("arst_dbz", int'(rsp_dbz), 0);
      chk("arst_req_ready", int'(req_ready), 0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (12) begin @(negedge clk); if (rsp_valid) seen = 1; end
      chk("no_rsp_after_rst", seen, 0);
      run_op(3, 200, 9, 22, 2, 0, 9);
      wait_sb(20);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one iterative restoring divider (2W-bit dividend, W-bit divisor) between NREQ requesters.
- Performs round-robin grant, operand capture, sequencing of the divide core, a response handshake, and divide-by-zero handling.
- Sits between client blocks and the shared divide datapath.
- Handles only one division at a time.

Parameters:
WIDTH, 4, divisor width W; dividend, quotient and remainder are 2*WIDTH bits.
NREQ, 4, number of requesters, range 2..16.
IDW, $clog2(NREQ), requester id width (derived localparam, not overridable).

Ports:
clk  in  1  sole clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  NREQ  per-requester request valid.
req_ready  out  NREQ  per-requester grant; one-hot or zero.
req_dividend  in  NREQ*2*WIDTH  packed; requester i occupies bits [i*2W +: 2W].
req_divisor  in  NREQ*WIDTH  packed; requester i occupies bits [i*W +: W].
rsp_valid  out  1  result available.
rsp_ready  in  1  consumer accepts result.
rsp_id  out  IDW  requester that owns the result.
rsp_quo  out  2*WIDTH  quotient.
rsp_rem  out  2*WIDTH  remainder, zero-extended.
rsp_dbz  out  1  divide-by-zero flag.
busy  out  1  high in RUN or RESP.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=NREQ-1, so requester 0 has first priority.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_quo=0, rsp_rem=0, rsp_dbz=0, busy=0.
  - Internal operand, partial-remainder and iteration-count registers are 0.
- IDLE:
  - req_ready is combinational: one-hot on the first asserted req_valid searching from rr_ptr+1 with wrap-around.
  - req_ready=0 when no request is valid.
  - Grant cycle T is when req_valid[g]&req_ready[g]. At T+1: operands latched, rsp_id=g, rr_ptr=g.
  - If latched divisor==0, go to RESP. Otherwise go to RUN.
- RUN:
  - Restoring division, one quotient bit per cycle, MSB first, exactly 2*WIDTH cycles.
  - Each cycle: partial remainder shifted left and next dividend bit appended (2W+1 bits wide, no overflow); trial-subtract divisor; keep the difference if non-negative; the quotient bit is the carry-out.
  - After the last iteration, go to RESP.
  - rsp_valid rises at T+2*WIDTH+1.
- RESP:
  - rsp_valid=1. rsp_id, rsp_quo, rsp_rem and rsp_dbz are held stable until rsp_valid&rsp_ready.
  - On that handshake, go to IDLE. The next grant is possible in the cycle after the handshake (no same-cycle re-grant).
- Divide-by-zero: rsp_quo = all ones (2W bits), rsp_rem = dividend, rsp_dbz=1, rsp_valid at T+1.
- Normal results: rsp_dbz=0, and quo*divisor+rem == dividend with rem < divisor.
- req_ready is 0 in RUN and RESP. Requests that arrive then wait; their valid must be held by the requester.
- Requester inputs are not sampled after the grant cycle; later changes do not affect the running operation.
- Simultaneous requests in IDLE: round-robin order only; no starvation (worst-case wait is NREQ-1 operations).
- rst asserted mid-RUN or mid-RESP: the operation is discarded, outputs drop to reset values immediately, and no response is produced.

Optional Feature:
DIV_ARB_FAST_PATH_EN:
- Defined: if the latched dividend < divisor and divisor != 0, skip RUN. RESP at T+1 with quo=0, rem=dividend, rsp_dbz=0.
- Undefined: such operands take the full 2*WIDTH cycles and give an identical numeric result.
- Divide-by-zero behaviour is unchanged either way.

Decomposition:
- Package div_pkg holds:
  - state enum IDLE/RUN/RESP;
  - DBZ quotient constant function (all ones for a given width);
  - default WIDTH and NREQ constants.
- Sub-module div_core:
  - Inputs: start, dividend, divisor. Outputs: done pulse, quo, rem.
  - Contains the iteration counter and partial-remainder datapath.
- div_arbiter keeps the grant logic, operand muxing, FSM and response registers.

Test Plan:
- WIDTH=4, NREQ=4 for all scenarios.
- Single request, req1 dividend=100 divisor=7 -> rsp_id=1, quo=14, rem=2, dbz=0, rsp_valid exactly 9 cycles after grant.
- req2 dividend=45 divisor=0 -> quo=255, rem=45, dbz=1, rsp_valid 1 cycle after grant.
- All four req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0; each result matches its own operands.
- rsp_ready low for 5 cycles in RESP -> rsp_* stable, req_ready=0, busy=1; completes the cycle after rsp_ready rises.
- rst pulsed at RUN cycle 4 -> all outputs 0 asynchronously; no rsp_valid; after release, a req3 request is granted and divides correctly.
- Boundaries: 255/1 -> quo=255, rem=0; 255/15 -> quo=17, rem=0; 3/9 -> quo=0, rem=3 (1-cycle latency with DIV_ARB_FAST_PATH_EN, 9 cycles without).
